// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I-subset sequencer: states, opcode
// classes, ALUOp values, fault codes and the combinational strobe bundle.
package riscv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEM       = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_TRAP      = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CLS_ILLEGAL = 3'd0,
        CLS_R       = 3'd1,
        CLS_I       = 3'd2,
        CLS_LOAD    = 3'd3,
        CLS_STORE   = 3'd4
    } class_e;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [1:0] ALU_OP_ADD = 2'b00;
    localparam logic [1:0] ALU_OP_R   = 2'b10;
    localparam logic [1:0] ALU_OP_I   = 2'b11;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b01;
    localparam logic [1:0] ERR_FETCH_TO = 2'b10;
    localparam logic [1:0] ERR_DATA_TO  = 2'b11;

    typedef struct packed {
        logic       imem_req;
        logic       dmem_read;
        logic       dmem_write;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic       alu_src;
        logic       mem2reg;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic class_e decode_class(input logic [6:0] op);
        case (op)
            OP_R:     return CLS_R;
            OP_I:     return CLS_I;
            OP_LOAD:  return CLS_LOAD;
            OP_STORE: return CLS_STORE;
            default:  return CLS_ILLEGAL;
        endcase
    endfunction

    // {alu_src, alu_op}: address generation (rs1 + imm) for everything but R/I.
    function automatic logic [2:0] alu_ctrl(input class_e cls);
        case (cls)
            CLS_R:   return {1'b0, ALU_OP_R};
            CLS_I:   return {1'b1, ALU_OP_I};
            default: return {1'b1, ALU_OP_ADD};
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Shared instruction/data memory request port of the multi-cycle sequencer.
interface multicycle_controller_if;

    // A request strobe (imem_req, dmem_read or dmem_write) acts as valid: once
    // raised it stays high and unchanged until the cycle mem_ready is seen high,
    // which completes the transfer. mem_ready with no request pending is ignored.
    logic imem_req;
    logic dmem_read;
    logic dmem_write;
    logic mem_ready;

    modport master (
        output imem_req,
        output dmem_read,
        output dmem_write,
        input  mem_ready
    );

    modport slave (
        input  imem_req,
        input  dmem_read,
        input  dmem_write,
        output mem_ready
    );

endinterface

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles a memory request waits without mem_ready and flags
// the last permitted waiting cycle. TIMEOUT_CYCLES == 0 never expires.
module mem_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic wait_i,
    output logic expired_o
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    // Every request state is entered from a non-waiting cycle, so clearing on
    // any non-waiting cycle is the same as clearing on entry.
    always_comb begin
        cnt_d = '0;
        if (wait_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (TIMEOUT_CYCLES != 0) && wait_i &&
                       (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/multicycle_controller.sv
// FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer driving the datapath strobes,
// counting retired instructions and trapping on illegal opcodes or timeouts.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 15,
    parameter int unsigned INSTRET_W      = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [6:0]             opcode,
    multicycle_controller_if.master mem,
    output logic                   ir_write,
    output logic                   pc_write,
    output logic                   reg_write,
    output logic                   alu_src,
    output logic                   mem2reg,
    output logic [1:0]             alu_op,
    output logic                   trap,
    output logic [1:0]             err_code,
    output logic [INSTRET_W-1:0]   instret,
    output logic [2:0]             state
);

    state_e                state_q, state_d;
    class_e                cls_q, cls_d;
    logic [1:0]            err_q, err_d;
    logic [INSTRET_W-1:0]  instret_q, instret_d;
    ctrl_t                 ctl, ctl_out;
    logic                  waiting;
    logic                  expired;
    logic                  retire;

    assign waiting = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !mem.mem_ready;

    mem_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk       (clk),
        .rst_n     (reset),
        .wait_i    (waiting),
        .expired_o (expired)
    );

    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        err_d     = err_q;
        ctl       = '0;
        retire    = 1'b0;
        instret_d = instret_q;

        case (state_q)
            ST_FETCH: begin
                ctl.imem_req = 1'b1;
                if (mem.mem_ready) begin
                    ctl.ir_write = 1'b1;
                    ctl.pc_write = 1'b1;
                    state_d      = ST_DECODE;
                end else if (expired) begin
                    state_d = ST_TRAP;
                    err_d   = ERR_FETCH_TO;
                end
            end
            ST_DECODE: begin
                cls_d = decode_class(opcode);
                if (cls_d == CLS_ILLEGAL) begin
                    state_d = ST_TRAP;
                    err_d   = ERR_ILLEGAL;
                end else begin
                    state_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                {ctl.alu_src, ctl.alu_op} = alu_ctrl(cls_q);
                state_d = ((cls_q == CLS_R) || (cls_q == CLS_I)) ? ST_WRITEBACK : ST_MEM;
            end
            ST_MEM: begin
                ctl.alu_src    = 1'b1;
                ctl.alu_op     = ALU_OP_ADD;
                ctl.dmem_read  = (cls_q == CLS_LOAD);
                ctl.dmem_write = (cls_q == CLS_STORE);
                if (mem.mem_ready) begin
                    if (cls_q == CLS_LOAD) begin
                        state_d = ST_WRITEBACK;
                    end else begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end
                end else if (expired) begin
                    state_d = ST_TRAP;
                    err_d   = ERR_DATA_TO;
                end
            end
            ST_WRITEBACK: begin
                {ctl.alu_src, ctl.alu_op} = alu_ctrl(cls_q);
                ctl.reg_write = 1'b1;
                ctl.mem2reg   = (cls_q == CLS_LOAD);
                retire        = 1'b1;
                state_d       = ST_FETCH;
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        if (retire) begin
            instret_d = instret_q + INSTRET_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_FETCH;
            cls_q     <= CLS_ILLEGAL;
            err_q     <= ERR_NONE;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            err_q     <= err_d;
            instret_q <= instret_d;
        end
    end

    // The strobes are Mealy outputs of a register that sits in FETCH during
    // reset, so they are masked directly by the reset level.
    assign ctl_out = reset ? ctl : '0;

    assign mem.imem_req   = ctl_out.imem_req;
    assign mem.dmem_read  = ctl_out.dmem_read;
    assign mem.dmem_write = ctl_out.dmem_write;
    assign ir_write       = ctl_out.ir_write;
    assign pc_write       = ctl_out.pc_write;
    assign reg_write      = ctl_out.reg_write;
    assign alu_src        = ctl_out.alu_src;
    assign mem2reg        = ctl_out.mem2reg;
    assign alu_op         = ctl_out.alu_op;

    assign trap     = (state_q == ST_TRAP);
    assign err_code = err_q;
    assign instret  = instret_q;
    assign state    = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller built with TIMEOUT_CYCLES = 4.
module tb_multicycle_controller;

  logic        clk;
  logic        reset;
  logic [6:0]  opcode;
  logic        ir_write, pc_write, reg_write, alu_src, mem2reg, trap;
  logic [1:0]  alu_op, err_code;
  logic [31:0] instret;
  logic [2:0]  state;
  logic [9:0]  strobes;
  int          checks;
  int          errors;

  multicycle_controller_if mem_bus ();

  multicycle_controller #(
    .TIMEOUT_CYCLES(4),
    .INSTRET_W(32)
  ) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem(mem_bus),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_src(alu_src), .mem2reg(mem2reg), .alu_op(alu_op), .trap(trap),
    .err_code(err_code), .instret(instret), .state(state)
  );

  // {imem_req, dmem_read, dmem_write, ir_write, pc_write, reg_write, alu_src, mem2reg, alu_op}
  assign strobes = {mem_bus.imem_req, mem_bus.dmem_read, mem_bus.dmem_write, ir_write,
                    pc_write, reg_write, alu_src, mem2reg, alu_op};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    reset = 1'b0;
    mem_bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    opcode = 7'b0110011;
    mem_bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (strobes !== 10'b0 || state !== 3'd0) begin
      errors++;
      $display("FAIL reset_strobes strobes=%b state=%0d exp strobes=0 state=0", strobes, state);
    end
    checks++;
    if (trap !== 1'b0 || err_code !== 2'b00 || instret !== 32'd0) begin
      errors++;
      $display("FAIL reset_regs trap=%b err=%b instret=%0d exp 0/00/0", trap, err_code, instret);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    mem_bus.mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (strobes !== 10'b1000000000 || state !== 3'd0) begin
      errors++;
      $display("FAIL reset_release strobes=%b state=%0d exp strobes=1000000000 state=0", strobes, state);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_r_type();
    int rdy [5];
    int st [5];
    logic [9:0] sb [5];
    rdy = '{1, 1, 1, 1, 0};
    st  = '{0, 1, 2, 4, 0};
    sb  = '{10'b1001100000, 10'b0000000000, 10'b0000000010, 10'b0000010010, 10'b1000000000};
    opcode = 7'b0110011;
    for (int i = 0; i < 5; i++) begin
      mem_bus.mem_ready = (rdy[i] != 0);
      @(negedge clk);
      checks++;
      if (state !== 3'(st[i]) || strobes !== sb[i]) begin
        errors++;
        $display("FAIL r_type c%0d state=%0d strobes=%b exp state=%0d strobes=%b", i, state, strobes, st[i], sb[i]);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (instret !== 32'd1) begin
      errors++;
      $display("FAIL r_type_instret got %0d exp 1", instret);
    end
  endtask

  task automatic test_i_type();
    int rdy [5];
    int st [5];
    logic [9:0] sb [5];
    rdy = '{1, 1, 1, 1, 0};
    st  = '{0, 1, 2, 4, 0};
    sb  = '{10'b1001100000, 10'b0000000000, 10'b0000001011, 10'b0000011011, 10'b1000000000};
    for (int i = 0; i < 5; i++) begin
      // After DECODE the live opcode turns illegal; only the registered class may matter.
      opcode = (i <= 1) ? 7'b0010011 : 7'b1111111;
      mem_bus.mem_ready = (rdy[i] != 0);
      @(negedge clk);
      checks++;
      if (state !== 3'(st[i]) || strobes !== sb[i]) begin
        errors++;
        $display("FAIL i_type c%0d state=%0d strobes=%b exp state=%0d strobes=%b", i, state, strobes, st[i], sb[i]);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (instret !== 32'd2) begin
      errors++;
      $display("FAIL i_type_instret got %0d exp 2", instret);
    end
  endtask

  task automatic test_load();
    int rdy [9];
    int st [9];
    logic [9:0] sb [9];
    logic [9:0] mask;
    rdy = '{1, 1, 1, 0, 0, 0, 1, 0, 0};
    st  = '{0, 1, 2, 3, 3, 3, 3, 4, 0};
    sb  = '{10'b1001100000, 10'b0000000000, 10'b0000001000, 10'b0100001000, 10'b0100001000,
            10'b0100001000, 10'b0100001000, 10'b0000010100, 10'b1000000000};
    for (int i = 0; i < 9; i++) begin
      opcode = (i <= 1) ? 7'b0000011 : 7'b0110011;
      mem_bus.mem_ready = (rdy[i] != 0);
      mask = (st[i] == 4) ? 10'b1111110100 : 10'b1111111111;
      @(negedge clk);
      checks++;
      if (state !== 3'(st[i]) || (strobes & mask) !== sb[i]) begin
        errors++;
        $display("FAIL load c%0d state=%0d strobes=%b exp state=%0d strobes=%b", i, state, strobes & mask, st[i], sb[i]);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (instret !== 32'd3) begin
      errors++;
      $display("FAIL load_instret got %0d exp 3", instret);
    end
  endtask

  task automatic test_store();
    int rdy [5];
    int st [5];
    logic [9:0] sb [5];
    rdy = '{1, 0, 0, 1, 0};
    st  = '{0, 1, 2, 3, 0};
    sb  = '{10'b1001100000, 10'b0000000000, 10'b0000001000, 10'b0010001000, 10'b1000000000};
    opcode = 7'b0100011;
    for (int i = 0; i < 5; i++) begin
      mem_bus.mem_ready = (rdy[i] != 0);
      @(negedge clk);
      checks++;
      if (state !== 3'(st[i]) || strobes !== sb[i]) begin
        errors++;
        $display("FAIL store c%0d state=%0d strobes=%b exp state=%0d strobes=%b", i, state, strobes, st[i], sb[i]);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (instret !== 32'd4) begin
      errors++;
      $display("FAIL store_instret got %0d exp 4", instret);
    end
  endtask

  task automatic test_fetch_wait_accept();
    int rdy [8];
    int st [8];
    logic [9:0] sb [8];
    rdy = '{0, 0, 0, 1, 0, 0, 0, 0};
    st  = '{0, 0, 0, 0, 1, 2, 4, 0};
    sb  = '{10'b1000000000, 10'b1000000000, 10'b1000000000, 10'b1001100000,
            10'b0000000000, 10'b0000000010, 10'b0000010010, 10'b1000000000};
    do_reset();
    opcode = 7'b0110011;
    for (int i = 0; i < 8; i++) begin
      mem_bus.mem_ready = (rdy[i] != 0);
      @(negedge clk);
      checks++;
      if (state !== 3'(st[i]) || strobes !== sb[i]) begin
        errors++;
        $display("FAIL fetch_wait c%0d state=%0d strobes=%b exp state=%0d strobes=%b", i, state, strobes, st[i], sb[i]);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (trap !== 1'b0 || instret !== 32'd1) begin
      errors++;
      $display("FAIL fetch_wait_end trap=%b instret=%0d exp trap=0 instret=1", trap, instret);
    end
  endtask

  task automatic test_fetch_timeout();
    do_reset();
    opcode = 7'b0110011;
    for (int i = 0; i < 5; i++) begin
      mem_bus.mem_ready = (i == 4);
      @(negedge clk);
      checks++;
      if (i < 4 && (state !== 3'd0 || strobes !== 10'b1000000000 || trap !== 1'b0)) begin
        errors++;
        $display("FAIL fetch_timeout c%0d state=%0d strobes=%b trap=%b exp 0/1000000000/0", i, state, strobes, trap);
      end else if (i == 4 && (state !== 3'd5 || strobes !== 10'b0 || trap !== 1'b1 || err_code !== 2'b10)) begin
        errors++;
        $display("FAIL fetch_timeout_trap state=%0d strobes=%b trap=%b err=%b exp 5/0/1/10", state, strobes, trap, err_code);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_data_timeout();
    int rdy [8];
    int st [8];
    logic [9:0] sb [8];
    rdy = '{1, 0, 0, 0, 0, 0, 0, 1};
    st  = '{0, 1, 2, 3, 3, 3, 3, 5};
    sb  = '{10'b1001100000, 10'b0000000000, 10'b0000001000, 10'b0010001000,
            10'b0010001000, 10'b0010001000, 10'b0010001000, 10'b0000000000};
    do_reset();
    opcode = 7'b0100011;
    for (int i = 0; i < 8; i++) begin
      mem_bus.mem_ready = (rdy[i] != 0);
      @(negedge clk);
      checks++;
      if (state !== 3'(st[i]) || strobes !== sb[i]) begin
        errors++;
        $display("FAIL data_timeout c%0d state=%0d strobes=%b exp state=%0d strobes=%b", i, state, strobes, st[i], sb[i]);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (trap !== 1'b1 || err_code !== 2'b11 || instret !== 32'd0) begin
      errors++;
      $display("FAIL data_timeout_err trap=%b err=%b instret=%0d exp 1/11/0", trap, err_code, instret);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    do_reset();
    opcode = 7'b1111111;
    mem_bus.mem_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    mem_bus.mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== 3'd1 || strobes !== 10'b0) begin
      errors++;
      $display("FAIL illegal_decode state=%0d strobes=%b exp state=1 strobes=0", state, strobes);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      mem_bus.mem_ready = (i % 3 == 0);
      opcode = (i % 2 == 0) ? 7'b0110011 : 7'b1111111;
      @(negedge clk);
      checks++;
      if (state !== 3'd5 || strobes !== 10'b0 || trap !== 1'b1 || err_code !== 2'b01) begin
        errors++;
        $display("FAIL illegal_trap c%0d state=%0d strobes=%b trap=%b err=%b exp 5/0/1/01", i, state, strobes, trap, err_code);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    opcode = 7'b0110011;
    mem_bus.mem_ready = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    opcode = 7'b0000011;
    repeat (3) begin
      @(posedge clk); #1;
    end
    mem_bus.mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== 3'd3 || strobes !== 10'b0100001000 || instret !== 32'd1) begin
      errors++;
      $display("FAIL mid_load_pre state=%0d strobes=%b instret=%0d exp 3/0100001000/1", state, strobes, instret);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (state !== 3'd0 || strobes !== 10'b0 || instret !== 32'd0 || trap !== 1'b0) begin
      errors++;
      $display("FAIL mid_load_async state=%0d strobes=%b instret=%0d trap=%b exp all 0", state, strobes, instret, trap);
    end
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== 3'd0 || strobes !== 10'b1000000000 || instret !== 32'd0 || trap !== 1'b0 || err_code !== 2'b00) begin
      errors++;
      $display("FAIL mid_load_release state=%0d strobes=%b instret=%0d trap=%b err=%b exp 0/1000000000/0/0/00",
               state, strobes, instret, trap, err_code);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    opcode = 7'b0;
    mem_bus.mem_ready = 1'b0;
    test_reset();
    test_r_type();
    test_i_type();
    test_load();
    test_store();
    test_fetch_wait_accept();
    test_fetch_timeout();
    test_data_timeout();
    test_illegal();
    test_reset_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Multi-cycle sequencer for the RV32I-subset datapath. It replaces single-cycle control with a FETCH/DECODE/EXECUTE/MEM/WRITEBACK state machine, so instruction and data memory can share variable-latency ports through a ready handshake. It drives the datapath strobes (PC/IR write, register write, memory read/write, ALU source/op, mem-to-reg), counts retired instructions, and traps on illegal opcodes or memory timeout.

Parameters:
TIMEOUT_CYCLES, 15, max cycles a memory request waits for mem_ready before trapping; 0 disables the timeout
INSTRET_W, 32, width of the retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
opcode  input  7  instruction opcode from IR; sampled only in DECODE
mem_ready  input  1  memory completion for the current imem/dmem request
imem_req  output  1  instruction fetch request
dmem_read  output  1  data load request
dmem_write  output  1  data store request
ir_write  output  1  capture fetched instruction into IR
pc_write  output  1  PC <= PC+4
reg_write  output  1  register file write enable
alu_src  output  1  0 = rs2, 1 = immediate
mem2reg  output  1  writeback source: 1 = load data
alu_op  output  2  ALUOp to ALU controller
trap  output  1  sticky fault flag
err_code  output  2  00 none, 01 illegal opcode, 10 fetch timeout, 11 data timeout
instret  output  INSTRET_W  retired instruction count, wraps
state  output  3  current state, for debug

Behaviour:
- Reset (reset==0, async):
  - state = FETCH; class register, wait counter, instret, trap and err_code cleared.
  - All outputs 0 while reset is low.
  - imem_req rises the first cycle after reset deasserts.
- Classes are decoded in DECODE and registered; later states use only the registered class, never the live opcode:
  - R = 0110011
  - I-ALU = 0010011
  - LOAD = 0000011
  - STORE = 0100011
  - Anything else is illegal.
- FETCH:
  - imem_req=1.
  - On mem_ready: ir_write=1 and pc_write=1, combinational (Mealy) in that same cycle; next state DECODE.
- DECODE: one cycle, no strobes. Legal -> EXECUTE; illegal -> TRAP with err_code=01.
- EXECUTE: one cycle.
  - R: alu_src=0, alu_op=ALU_OP_R (10).
  - I-ALU: alu_src=1, alu_op=ALU_OP_I (11).
  - LOAD/STORE: alu_src=1, alu_op=ALU_OP_ADD (00).
  - R/I -> WRITEBACK; LOAD/STORE -> MEM.
- MEM:
  - alu_src=1 and alu_op=00 are held throughout.
  - LOAD holds dmem_read=1; STORE holds dmem_write=1.
  - On mem_ready: LOAD -> WRITEBACK; STORE retires and goes to FETCH.
- WRITEBACK:
  - reg_write=1 for exactly one cycle.
  - mem2reg=1 for LOAD, else 0.
  - EXECUTE's alu_src/alu_op are held for R/I.
  - Retire, then FETCH.
- TRAP:
  - All strobes 0; trap=1.
  - err_code holds its value; the block stays in TRAP until reset.
- Request handshake:
  - Request strobes stay high and stable until the cycle mem_ready is seen.
  - mem_ready is ignored in states with no request.
- Wait counter:
  - Cleared on entering FETCH or MEM.
  - Increments each waiting cycle without mem_ready.
  - If TIMEOUT_CYCLES != 0 and the counter equals TIMEOUT_CYCLES-1 with mem_ready low: TRAP, err_code 10 (FETCH) or 11 (MEM).
  - mem_ready arriving on the TIMEOUT_CYCLES-th wait cycle is accepted.
- Retire: instret+1 on the WRITEBACK cycle or on the STORE mem_ready cycle. Wraps modulo 2^INSTRET_W.
- Latency with zero-wait memory: R/I 4 cycles, STORE 4, LOAD 5. Each wait cycle adds 1.
- Reset mid-operation aborts immediately; no partial strobe survives the reset edge.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - state encoding: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, TRAP=5
  - opcode constants OP_R, OP_I, OP_LOAD, OP_STORE
  - ALU_OP_ADD/R/I
  - err_code constants
- One natural sub-module: mem_wait_timer (counter plus timeout compare, parameterised by TIMEOUT_CYCLES).
- FSM and output decode stay in the top.

Test Plan:
- R-type (opcode 0110011), mem_ready tied 1 -> states 0,1,2,4,0; reg_write=1 one cycle in cycle 4; alu_op=10, alu_src=0; instret 0->1.
- LOAD (0000011), dmem mem_ready after 3 wait cycles -> dmem_read high 4 consecutive cycles; next cycle reg_write=1, mem2reg=1; total 8 cycles; instret+1.
- STORE (0100011), mem_ready on the first MEM cycle -> dmem_write=1 one cycle; no reg_write; back in FETCH; instret+1.
- Illegal opcode 1111111 -> DECODE->TRAP; trap=1, err_code=01; all strobes 0 for 20 cycles even with mem_ready pulsed.
- TIMEOUT_CYCLES=4, mem_ready never asserted in FETCH -> TRAP after 4 imem_req cycles, err_code=10. Repeat with mem_ready on wait cycle 4 -> accepted, no trap.
- Reset pulled low during MEM of a LOAD -> outputs 0 asynchronously; after release state=FETCH, instret=0, trap=0.
